// File: rtl/fpu_unary_sched.sv
// fpu_unary_sched
//   Shares one fixed-latency unary FP unit (floor/ftoi/itof/fsqrt) between NREQ requesters.
//   A round-robin arbiter issues at most one op per cycle. Each issued op carries its source
//   index and tag down a shift register that mirrors the unit latency. When the op leaves the
//   unit, its result is pushed into a show-ahead result FIFO. Issue is gated by credits, so the
//   FIFO can never overflow while the consumer back-pressures.
//
// Ports
//   clk, rstn                     clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready           per-requester handshake; req_ready is one-hot or zero
//   req_op/req_x/req_tag          per-requester op (0 floor, 1 ftoi, 2 itof, 3 fsqrt),
//                                 operand and tag, packed with requester 0 in the low bits
//   u_valid/u_op/u_x              issue strobe and payload to the unit
//   u_y/u_ovf                     unit result, valid LATENCY cycles after u_valid
//   res_valid/res_ready           result FIFO head handshake
//   res_y/res_ovf/res_src/res_tag head entry; all zero while the FIFO is empty
//   busy                          any op in flight or any result queued
module fpu_unary_sched #(
  parameter int unsigned NREQ      = 2,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [2*NREQ-1:0]        req_op,
  input  logic [32*NREQ-1:0]       req_x,
  input  logic [TAG_W*NREQ-1:0]    req_tag,
  output logic                     u_valid,
  output logic [1:0]               u_op,
  output logic [31:0]              u_x,
  input  logic [31:0]              u_y,
  input  logic                     u_ovf,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [31:0]              res_y,
  output logic                     res_ovf,
  output logic [$clog2(NREQ)-1:0]  res_src,
  output logic [TAG_W-1:0]         res_tag,
  output logic                     busy
);

  localparam int unsigned SRC_W = $clog2(NREQ);
  localparam int unsigned PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);
  localparam int unsigned INF_W = $clog2(LATENCY + 2);
  localparam int unsigned ENT_W = 1 + 32 + SRC_W + TAG_W;

  // ---------------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------------
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0] mem_q [RES_DEPTH];

  // ---------------------------------------------------------------------------------------------
  // Arbitration and issue
  // ---------------------------------------------------------------------------------------------
  logic             gnt_found;
  logic [SRC_W-1:0] gnt_idx;
  logic [SRC_W:0]   cand;
  logic             issue;
  logic [TAG_W-1:0] sel_tag;
  logic [INF_W-1:0] inflight;
  logic [31:0]      used;
  logic             has_credit;

  // Credits come from registered state only, so a pop in this cycle cannot fund an issue in
  // this same cycle.
  assign used       = 32'(inflight) + 32'(fifo_cnt_q);
  assign has_credit = (used < RES_DEPTH);

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    // Search NREQ candidates starting at the round-robin pointer; first valid one wins.
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (SRC_W + 1)'(i);
      if (32'(cand) >= NREQ) begin
        cand = cand - (SRC_W + 1)'(NREQ);
      end
      if (!gnt_found && req_valid[cand[SRC_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand[SRC_W-1:0];
      end
    end
  end

  // rstn gates issue so nothing is granted while the tracking state is held in reset.
  assign issue = rstn & gnt_found & has_credit;

  always_comb begin
    req_ready = '0;
    u_valid   = issue;
    u_op      = '0;
    u_x       = '0;
    sel_tag   = '0;
    if (issue) begin
      req_ready[gnt_idx] = 1'b1;
      u_op               = req_op[32'(gnt_idx) * 2 +: 2];
      u_x                = req_x[32'(gnt_idx) * 32 +: 32];
      sel_tag            = req_tag[32'(gnt_idx) * TAG_W +: TAG_W];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (32'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // In-flight tracking: one stage per cycle of unit latency
  // ---------------------------------------------------------------------------------------------
  logic             push;
  logic [SRC_W-1:0] push_src;
  logic [TAG_W-1:0] push_tag;

  if (LATENCY == 0) begin : g_comb_unit
    // Combinational unit: the result is available in the issue cycle itself.
    assign push     = issue;
    assign push_src = gnt_idx;
    assign push_tag = sel_tag;
    assign inflight = '0;
  end else begin : g_pipe
    logic [LATENCY-1:0] pv_q, pv_d;
    logic [SRC_W-1:0]   psrc_q [LATENCY];
    logic [SRC_W-1:0]   psrc_d [LATENCY];
    logic [TAG_W-1:0]   ptag_q [LATENCY];
    logic [TAG_W-1:0]   ptag_d [LATENCY];

    always_comb begin
      pv_d[0]   = issue;
      psrc_d[0] = gnt_idx;
      ptag_d[0] = sel_tag;
      for (int unsigned s = 1; s < LATENCY; s++) begin
        pv_d[s]   = pv_q[s-1];
        psrc_d[s] = psrc_q[s-1];
        ptag_d[s] = ptag_q[s-1];
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        pv_q <= '0;
        for (int unsigned s = 0; s < LATENCY; s++) begin
          psrc_q[s] <= '0;
          ptag_q[s] <= '0;
        end
      end else begin
        pv_q <= pv_d;
        for (int unsigned s = 0; s < LATENCY; s++) begin
          psrc_q[s] <= psrc_d[s];
          ptag_q[s] <= ptag_d[s];
        end
      end
    end

    assign push     = pv_q[LATENCY-1];
    assign push_src = psrc_q[LATENCY-1];
    assign push_tag = ptag_q[LATENCY-1];
    assign inflight = INF_W'($countones(pv_q));
  end

  // ---------------------------------------------------------------------------------------------
  // Result FIFO (show-ahead)
  // ---------------------------------------------------------------------------------------------
  logic             pop;
  logic [ENT_W-1:0] head;

  assign res_valid = (fifo_cnt_q != '0);
  assign pop       = res_valid & res_ready;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    if (push) begin
      wr_ptr_d = (32'(wr_ptr_q) == RES_DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (32'(rd_ptr_q) == RES_DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
    end
    // Credits guarantee push never lands on a full FIFO, so no overflow guard is needed.
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + 1'b1;
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {u_ovf, u_y, push_src, push_tag};
    end
  end

  assign head = mem_q[rd_ptr_q];
  assign {res_ovf, res_y, res_src, res_tag} = res_valid ? head : '0;

  assign busy = (inflight != '0) | res_valid;

endmodule
